rvfi_commit_sequencer: RTL and testbench

Reorder and commit sequencer feeding the multi-lane RVFI monitor interface. Execution units finish instructions out of order; this block assigns each instruction its retirement `order` at dispatch and buffers completed RVFI packets in a circular buffer. It releases up to LANES packets per cycle, strictly in order, onto contiguous monitor lanes. It also detects halt and reports protocol misuse.

---
 rtl/rvfi_pkg.sv | 35 +++
 rtl/rvfi_drain_count.sv | 38 +++
 rtl/rvfi_commit_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rvfi_commit_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_pkg.sv
// Shared types and helpers for the RVFI commit sequencer.
//   rvfi_pkt_t : RVFI fields carried per instruction (order is tracked separately).
//   is_halt()  : identifies packets that end the instruction stream.
package rvfi_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_pkt_t;

  // beq x0,x0,0 and jal x0,0 are self-loops; slti x0,x0,-256 is a marker nop.
  localparam logic [31:0] HaltInstBeq    = 32'h0000_0063;
  localparam logic [31:0] HaltInstJal    = 32'h0000_006F;
  localparam logic [31:0] HaltInstMarker = 32'hF000_2013;

  function automatic logic is_halt(input logic [31:0] pc_rdata,
                                   input logic [31:0] pc_wdata,
                                   input logic [31:0] inst);
    return (pc_rdata == pc_wdata) || (inst == HaltInstBeq) || (inst == HaltInstJal) ||
           (inst == HaltInstMarker);
  endfunction

endpackage

// File: rtl/rvfi_drain_count.sv
// Drain-group sizing for the commit sequencer.
//   done_rot : done flags of the LANES oldest entries, bit 0 = head.
//   halt_rot : halt classification of the same entries.
//   k        : number of entries to release this cycle (leading ones, halt-truncated).
//   halt_hit : the last released entry is a halt packet.
module rvfi_drain_count #(
  parameter int unsigned LANES = 8,
  parameter int unsigned KW    = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] done_rot,
  input  logic [LANES-1:0] halt_rot,
  output logic [KW-1:0]    k,
  output logic             halt_hit
);

  logic stop;

  always_comb begin
    k        = '0;
    halt_hit = 1'b0;
    stop     = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (!stop) begin
        if (done_rot[j]) begin
          k = KW'(j + 1);
          // A halt packet is emitted but closes the group.
          if (halt_rot[j]) begin
            halt_hit = 1'b1;
            stop     = 1'b1;
          end
        end else begin
          stop = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_commit_sequencer.sv
// In-order commit sequencer for a multi-lane RVFI monitor.
//   alloc_*  : dispatch handshake; alloc_tag names the entry granted this cycle.
//   cmp_*    : NCMP out-of-order completion write ports (tag + packet).
//   mon_*    : registered commit lanes, valid lanes contiguous from lane 0.
//   halted   : sticky, set once a halt packet has committed.
//   err      : sticky protocol error (bad or conflicting completion).
module rvfi_commit_sequencer
  import rvfi_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LANES = 8,
  parameter int unsigned NCMP  = 2,
  localparam int unsigned TW   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [TW-1:0]              alloc_tag,
  input  logic [NCMP-1:0]            cmp_valid,
  input  logic [NCMP-1:0][TW-1:0]    cmp_tag,
  input  rvfi_pkt_t [NCMP-1:0]       cmp_pkt,
  output logic [LANES-1:0]           mon_valid,
  output logic [LANES-1:0][63:0]     mon_order,
  output rvfi_pkt_t [LANES-1:0]      mon_pkt,
  output logic                       halted,
  output logic                       err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned KW = $clog2(LANES + 1);

  logic [DEPTH-1:0]        alloc_q, alloc_d, done_q, done_d;
  logic [DEPTH-1:0][63:0]  order_q, order_d;
  rvfi_pkt_t [DEPTH-1:0]   pkt_q, pkt_d;
  logic [TW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [63:0]             order_ctr_q, order_ctr_d;
  logic                    halted_q, halted_d, err_q, err_d;
  logic [LANES-1:0]        mon_valid_q, mon_valid_d;
  logic [LANES-1:0][63:0]  mon_order_q, mon_order_d;
  rvfi_pkt_t [LANES-1:0]   mon_pkt_q, mon_pkt_d;

  logic                    alloc_fire;
  logic                    cmp_bad;
  logic [LANES-1:0]        done_rot, halt_rot;
  logic [KW-1:0]           k;
  logic                    halt_hit;

  // Ready looks only at the registered count; a same-cycle drain does not help.
  assign alloc_ready = (count_q != CW'(DEPTH)) && !halted_q;
  assign alloc_tag   = tail_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Window of the LANES oldest entries; masking done freezes draining once halted.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      done_rot[j] = done_q[head_q + TW'(j)] && !halted_q;
      halt_rot[j] = is_halt(pkt_q[head_q + TW'(j)].pc_rdata, pkt_q[head_q + TW'(j)].pc_wdata,
                            pkt_q[head_q + TW'(j)].inst);
    end
  end

  rvfi_drain_count #(
    .LANES (LANES)
  ) u_drain_count (
    .done_rot (done_rot),
    .halt_rot (halt_rot),
    .k        (k),
    .halt_hit (halt_hit)
  );

  always_comb begin
    alloc_d     = alloc_q;
    done_d      = done_q;
    order_d     = order_q;
    pkt_d       = pkt_q;
    tail_d      = tail_q;
    order_ctr_d = order_ctr_q;
    err_d       = err_q;
    cmp_bad     = 1'b0;
    halted_d    = halted_q | halt_hit;
    mon_valid_d = '0;
    mon_order_d = '0;
    mon_pkt_d   = '0;

    for (int j = 0; j < LANES; j++) begin
      if (j < int'(k)) begin
        mon_valid_d[j]              = 1'b1;
        mon_order_d[j]              = order_q[head_q + TW'(j)];
        mon_pkt_d[j]                = pkt_q[head_q + TW'(j)];
        alloc_d[head_q + TW'(j)]    = 1'b0;
        done_d[head_q + TW'(j)]     = 1'b0;
      end
    end
    head_d  = head_q + TW'(k);
    count_d = count_q + CW'(alloc_fire) - CW'(k);

    if (alloc_fire) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      order_d[tail_q] = order_ctr_q;
      tail_d          = tail_q + 1'b1;
      order_ctr_d     = order_ctr_q + 64'd1;
    end

    // Checks use registered flags, so completing a tag being allocated this
    // cycle sees alloc=0 and is rejected; colliding ports are both rejected.
    for (int i = 0; i < NCMP; i++) begin
      if (cmp_valid[i]) begin
        cmp_bad = !alloc_q[cmp_tag[i]] || done_q[cmp_tag[i]];
        for (int m = 0; m < NCMP; m++) begin
          if ((m != i) && cmp_valid[m] && (cmp_tag[m] == cmp_tag[i])) cmp_bad = 1'b1;
        end
        if (cmp_bad) begin
          err_d = 1'b1;
        end else begin
          done_d[cmp_tag[i]] = 1'b1;
          pkt_d[cmp_tag[i]]  = cmp_pkt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      order_ctr_q <= '0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      mon_valid_q <= '0;
      mon_order_q <= '0;
      mon_pkt_q   <= '0;
    end else begin
      alloc_q     <= alloc_d;
      done_q      <= done_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      order_ctr_q <= order_ctr_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      mon_valid_q <= mon_valid_d;
      mon_order_q <= mon_order_d;
      mon_pkt_q   <= mon_pkt_d;
    end
  end

  // Payload storage is only meaningful behind alloc/done, so it needs no reset.
  always_ff @(posedge clk) begin
    order_q <= order_d;
    pkt_q   <= pkt_d;
  end

  assign mon_valid = mon_valid_q;
  assign mon_order = mon_order_q;
  assign mon_pkt   = mon_pkt_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
module tb_rvfi_commit_sequencer;
  import rvfi_pkg::*;

  localparam int DEPTH = 16;
  localparam int LANES = 8;
  localparam int NCMP  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [3:0]             alloc_tag;
  logic [NCMP-1:0]        cmp_valid;
  logic [NCMP-1:0][3:0]   cmp_tag;
  rvfi_pkt_t [NCMP-1:0]   cmp_pkt;
  logic [LANES-1:0]       mon_valid;
  logic [LANES-1:0][63:0] mon_order;
  rvfi_pkt_t [LANES-1:0]  mon_pkt;
  logic                   halted;
  logic                   err;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [63:0] got_order[$];
  rvfi_pkt_t   got_pkt[$];
  bit          bad_shape;

  rvfi_commit_sequencer #(
    .DEPTH (DEPTH),
    .LANES (LANES),
    .NCMP  (NCMP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cmp_valid   (cmp_valid),
    .cmp_tag     (cmp_tag),
    .cmp_pkt     (cmp_pkt),
    .mon_valid   (mon_valid),
    .mon_order   (mon_order),
    .mon_pkt     (mon_pkt),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic bit ref_halt(rvfi_pkt_t p);
    return (p.pc_rdata == p.pc_wdata) || (p.inst == 32'h0000_0063) ||
           (p.inst == 32'h0000_006F) || (p.inst == 32'hF000_2013);
  endfunction

  function automatic rvfi_pkt_t rand_pkt();
    rvfi_pkt_t p;
    p.inst      = $urandom;
    p.rs1_addr  = 5'($urandom);
    p.rs2_addr  = 5'($urandom);
    p.rs1_rdata = $urandom;
    p.rs2_rdata = $urandom;
    p.rd_addr   = 5'($urandom);
    p.rd_wdata  = $urandom;
    p.pc_rdata  = $urandom;
    p.pc_wdata  = p.pc_rdata + 32'd4;
    p.mem_addr  = $urandom;
    p.mem_rmask = 4'($urandom);
    p.mem_wmask = 4'($urandom);
    p.mem_rdata = $urandom;
    p.mem_wdata = $urandom;
    while (ref_halt(p)) p.inst = $urandom;
    return p;
  endfunction

  // Advance one cycle, then record every committed lane in emission order.
  task automatic tick();
    logic [8:0] v;
    @(posedge clk);
    #1;
    for (int j = 0; j < LANES; j++) begin
      if (mon_valid[j]) begin
        got_order.push_back(mon_order[j]);
        got_pkt.push_back(mon_pkt[j]);
      end
    end
    v = {1'b0, mon_valid};
    if (((v + 9'd1) & v) != 9'd0) bad_shape = 1'b1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0;
    cmp_valid   = '0;
    cmp_tag     = '0;
    cmp_pkt     = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got_order.delete();
    got_pkt.delete();
    bad_shape = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    alloc_valid = 1'b1;
    repeat (n) tick();
    alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (mon_valid !== 8'h00) $display("FAIL reset_mon_valid got %h want 00", mon_valid); else pass_cnt++;
    total_cnt++; if (mon_order !== '0) $display("FAIL reset_mon_order got %h want 0", mon_order[0]); else pass_cnt++;
    total_cnt++; if (mon_pkt !== '0) $display("FAIL reset_mon_pkt got %h want 0", mon_pkt[0]); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); else pass_cnt++;
    total_cnt++; if (alloc_tag !== 4'd0) $display("FAIL reset_alloc_tag got %0d want 0", alloc_tag); else pass_cnt++;
  endtask

  task automatic test_in_order();
    rvfi_pkt_t p[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      p[i] = rand_pkt();
      total_cnt++; if (alloc_tag !== 4'(i)) $display("FAIL inorder_tag got %0d want %0d", alloc_tag, i); else pass_cnt++;
      alloc_valid = 1'b1;
      tick();
    end
    alloc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmp_valid = 2'b01; cmp_tag[0] = 4'(i); cmp_pkt[0] = p[i];
      tick();
      if (i == 0) begin
        total_cnt++; if (mon_valid !== 8'h00) $display("FAIL inorder_early got %h want 00", mon_valid); else pass_cnt++;
      end else begin
        total_cnt++; if (mon_valid !== 8'h01 || mon_order[0] !== 64'(i - 1) || mon_pkt[0] !== p[i-1])
          $display("FAIL inorder_lane got v=%h ord=%0d want v=01 ord=%0d", mon_valid, mon_order[0], i - 1);
        else pass_cnt++;
      end
    end
    clear_inputs();
    tick();
    total_cnt++; if (mon_valid !== 8'h01 || mon_order[0] !== 64'd2 || mon_pkt[0] !== p[2])
      $display("FAIL inorder_last got v=%h ord=%0d want v=01 ord=2", mon_valid, mon_order[0]);
    else pass_cnt++;
    tick();
    total_cnt++; if (mon_valid !== 8'h00) $display("FAIL inorder_hold got %h want 00", mon_valid); else pass_cnt++;
  endtask

  task automatic test_burst8();
    rvfi_pkt_t p[8];
    do_reset();
    alloc_n(8);
    for (int i = 0; i < 8; i++) p[i] = rand_pkt();
    for (int t = 7; t >= 1; t--) begin
      cmp_valid = '0;
      cmp_valid[t % 2] = 1'b1; cmp_tag[t % 2] = 4'(t); cmp_pkt[t % 2] = p[t];
      tick();
      total_cnt++; if (mon_valid !== 8'h00) $display("FAIL burst_wait got %h want 00 (tag %0d)", mon_valid, t); else pass_cnt++;
    end
    cmp_valid = 2'b01; cmp_tag[0] = 4'd0; cmp_pkt[0] = p[0];
    tick();
    clear_inputs();
    total_cnt++; if (mon_valid !== 8'h00) $display("FAIL burst_lat got %h want 00", mon_valid); else pass_cnt++;
    tick();
    total_cnt++; if (mon_valid !== 8'hFF) $display("FAIL burst_valid got %h want ff", mon_valid); else pass_cnt++;
    for (int j = 0; j < 8; j++) begin
      total_cnt++; if (mon_order[j] !== 64'(j) || mon_pkt[j] !== p[j])
        $display("FAIL burst_lane%0d got ord=%0d want ord=%0d", j, mon_order[j], j);
      else pass_cnt++;
    end
    tick();
    total_cnt++; if (mon_valid !== 8'h00) $display("FAIL burst_hold got %h want 00", mon_valid); else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    rvfi_pkt_t p[17];
    do_reset();
    for (int i = 0; i < 17; i++) p[i] = rand_pkt();
    for (int i = 0; i < 16; i++) begin
      total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL full_fill_ready got %b want 1 (i=%0d)", alloc_ready, i); else pass_cnt++;
      alloc_valid = 1'b1;
      tick();
    end
    alloc_valid = 1'b0;
    total_cnt++; if (alloc_ready !== 1'b0) $display("FAIL full_ready got %b want 0", alloc_ready); else pass_cnt++;
    cmp_valid = 2'b01; cmp_tag[0] = 4'd0; cmp_pkt[0] = p[0];
    tick();
    clear_inputs();
    total_cnt++; if (alloc_ready !== 1'b0) $display("FAIL full_no_bypass got %b want 0", alloc_ready); else pass_cnt++;
    tick();
    total_cnt++; if (alloc_ready !== 1'b1) $display("FAIL full_release got %b want 1", alloc_ready); else pass_cnt++;
    total_cnt++; if (alloc_tag !== 4'd0) $display("FAIL full_wrap_tag got %0d want 0", alloc_tag); else pass_cnt++;
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0;
    total_cnt++; if (alloc_ready !== 1'b0) $display("FAIL full_again got %b want 0", alloc_ready); else pass_cnt++;
    for (int t = 1; t <= 15; t += 2) begin
      cmp_valid = 2'b01; cmp_tag[0] = 4'(t); cmp_pkt[0] = p[t];
      if (t + 1 <= 15) begin
        cmp_valid[1] = 1'b1; cmp_tag[1] = 4'(t + 1); cmp_pkt[1] = p[t+1];
      end
      tick();
    end
    cmp_valid = 2'b01; cmp_tag[0] = 4'd0; cmp_pkt[0] = p[16];
    tick();
    clear_inputs();
    repeat (6) tick();
    total_cnt++; if (got_order.size() != 17) $display("FAIL full_count got %0d want 17", got_order.size()); else pass_cnt++;
    for (int i = 0; i < 17 && i < got_order.size(); i++) begin
      total_cnt++; if (got_order[i] !== 64'(i) || got_pkt[i] !== p[i])
        $display("FAIL full_stream[%0d] got ord=%0d want ord=%0d", i, got_order[i], i);
      else pass_cnt++;
    end
    total_cnt++; if (bad_shape !== 1'b0) $display("FAIL full_shape got %b want 0", bad_shape); else pass_cnt++;
  endtask

  task automatic test_halt();
    rvfi_pkt_t p[4];
    do_reset();
    alloc_n(4);
    for (int i = 0; i < 4; i++) p[i] = rand_pkt();
    p[2].inst = 32'h0000_006F;
    cmp_valid = 2'b11; cmp_tag[0] = 4'd3; cmp_pkt[0] = p[3]; cmp_tag[1] = 4'd2; cmp_pkt[1] = p[2];
    tick();
    total_cnt++; if (mon_valid !== 8'h00) $display("FAIL halt_wait got %h want 00", mon_valid); else pass_cnt++;
    cmp_tag[0] = 4'd1; cmp_pkt[0] = p[1]; cmp_tag[1] = 4'd0; cmp_pkt[1] = p[0];
    tick();
    clear_inputs();
    total_cnt++; if (halted !== 1'b0) $display("FAIL halt_early got %b want 0", halted); else pass_cnt++;
    tick();
    total_cnt++; if (mon_valid !== 8'h07) $display("FAIL halt_valid got %h want 07", mon_valid); else pass_cnt++;
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_flag got %b want 1", halted); else pass_cnt++;
    for (int j = 0; j < 3; j++) begin
      total_cnt++; if (mon_order[j] !== 64'(j) || mon_pkt[j] !== p[j])
        $display("FAIL halt_lane%0d got ord=%0d want ord=%0d", j, mon_order[j], j);
      else pass_cnt++;
    end
    repeat (5) tick();
    total_cnt++; if (got_order.size() != 3) $display("FAIL halt_stop got %0d want 3", got_order.size()); else pass_cnt++;
    total_cnt++; if (alloc_ready !== 1'b0) $display("FAIL halt_ready got %b want 0", alloc_ready); else pass_cnt++;
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b want 1", halted); else pass_cnt++;
  endtask

  task automatic test_err();
    rvfi_pkt_t pa, pb, p0;
    pa = rand_pkt(); pb = rand_pkt(); p0 = rand_pkt();
    // Double completion of a waiting (non-head) entry.
    do_reset();
    alloc_n(2);
    cmp_valid = 2'b01; cmp_tag[0] = 4'd1; cmp_pkt[0] = pa;
    tick();
    total_cnt++; if (err !== 1'b0) $display("FAIL err_legal got %b want 0", err); else pass_cnt++;
    cmp_pkt[0] = pb;
    tick();
    total_cnt++; if (err !== 1'b1) $display("FAIL err_double got %b want 1", err); else pass_cnt++;
    cmp_tag[0] = 4'd0; cmp_pkt[0] = p0;
    tick();
    clear_inputs();
    tick();
    total_cnt++; if (mon_valid !== 8'h03) $display("FAIL err_drain_valid got %h want 03", mon_valid); else pass_cnt++;
    total_cnt++; if (mon_pkt[1] !== pa || mon_pkt[0] !== p0)
      $display("FAIL err_no_corrupt got inst=%h want inst=%h", mon_pkt[1].inst, pa.inst);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else pass_cnt++;
    // Unallocated tag.
    do_reset();
    cmp_valid = 2'b01; cmp_tag[0] = 4'd5; cmp_pkt[0] = pa;
    tick();
    clear_inputs();
    total_cnt++; if (err !== 1'b1) $display("FAIL err_unalloc got %b want 1", err); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (got_order.size() != 0) $display("FAIL err_unalloc_emit got %0d want 0", got_order.size()); else pass_cnt++;
    // Allocate and complete the same tag in one cycle.
    do_reset();
    alloc_valid = 1'b1; cmp_valid = 2'b01; cmp_tag[0] = 4'd0; cmp_pkt[0] = pa;
    tick();
    clear_inputs();
    total_cnt++; if (err !== 1'b1) $display("FAIL err_same_cycle got %b want 1", err); else pass_cnt++;
    // Both ports naming one tag.
    do_reset();
    alloc_n(1);
    cmp_valid = 2'b11; cmp_tag[0] = 4'd0; cmp_tag[1] = 4'd0; cmp_pkt[0] = pa; cmp_pkt[1] = pb;
    tick();
    clear_inputs();
    total_cnt++; if (err !== 1'b1) $display("FAIL err_collide got %b want 1", err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rvfi_pkt_t p;
    do_reset();
    alloc_n(6);
    p = rand_pkt();
    cmp_valid = 2'b11; cmp_tag[0] = 4'd1; cmp_tag[1] = 4'd2; cmp_pkt[0] = p; cmp_pkt[1] = p;
    tick();
    cmp_tag[0] = 4'd3; cmp_tag[1] = 4'd4;
    tick();
    cmp_valid = 2'b01; cmp_tag[0] = 4'd0;
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_order.delete();
    got_pkt.delete();
    total_cnt++; if (mon_valid !== 8'h00) $display("FAIL rstmid_lanes got %h want 00", mon_valid); else pass_cnt++;
    repeat (4) tick();
    total_cnt++; if (got_order.size() != 0) $display("FAIL rstmid_emit got %0d want 0", got_order.size()); else pass_cnt++;
    total_cnt++; if (alloc_tag !== 4'd0 || alloc_ready !== 1'b1)
      $display("FAIL rstmid_alloc got tag=%0d rdy=%b want tag=0 rdy=1", alloc_tag, alloc_ready);
    else pass_cnt++;
    alloc_n(1);
    p = rand_pkt();
    cmp_valid = 2'b01; cmp_tag[0] = 4'd0; cmp_pkt[0] = p;
    tick();
    clear_inputs();
    tick();
    total_cnt++; if (mon_valid !== 8'h01 || mon_order[0] !== 64'd0 || mon_pkt[0] !== p)
      $display("FAIL rstmid_first got v=%h ord=%0d want v=01 ord=0", mon_valid, mon_order[0]);
    else pass_cnt++;
  endtask

  // Reference: every allocation receives the next order and tag (order mod DEPTH);
  // the committed stream must be all allocated orders, ascending, with their packets.
  task automatic test_random();
    rvfi_pkt_t exp_pkt[$];
    int        pend[$];
    int        tag_order[DEPTH];
    int        next_order;
    int        nc, idx, tg;
    do_reset();
    next_order = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_inputs();
      nc = $urandom_range(0, 2);
      for (int i = 0; i < nc && pend.size() > 0; i++) begin
        idx = $urandom_range(0, pend.size() - 1);
        tg = pend[idx];
        pend.delete(idx);
        cmp_valid[i] = 1'b1; cmp_tag[i] = 4'(tg); cmp_pkt[i] = exp_pkt[tag_order[tg]];
      end
      if ($urandom_range(0, 99) < ((cyc / 100) % 2 == 0 ? 70 : 40) && alloc_ready) begin
        total_cnt++; if (alloc_tag !== 4'(next_order % DEPTH))
          $display("FAIL rand_tag got %0d want %0d", alloc_tag, next_order % DEPTH);
        else pass_cnt++;
        alloc_valid = 1'b1;
        tag_order[next_order % DEPTH] = next_order;
        exp_pkt.push_back(rand_pkt());
        pend.push_back(next_order % DEPTH);
        next_order++;
      end
      tick();
    end
    clear_inputs();
    while (pend.size() > 0) begin
      cmp_valid = '0;
      for (int i = 0; i < NCMP && pend.size() > 0; i++) begin
        tg = pend.pop_front();
        cmp_valid[i] = 1'b1; cmp_tag[i] = 4'(tg); cmp_pkt[i] = exp_pkt[tag_order[tg]];
      end
      tick();
    end
    clear_inputs();
    repeat (20) tick();
    total_cnt++; if (err !== 1'b0) $display("FAIL rand_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (bad_shape !== 1'b0) $display("FAIL rand_shape got %b want 0", bad_shape); else pass_cnt++;
    total_cnt++; if (got_order.size() != exp_pkt.size())
      $display("FAIL rand_count got %0d want %0d", got_order.size(), exp_pkt.size());
    else pass_cnt++;
    for (int i = 0; i < exp_pkt.size() && i < got_order.size(); i++) begin
      total_cnt++; if (got_order[i] !== 64'(i) || got_pkt[i] !== exp_pkt[i])
        $display("FAIL rand_stream[%0d] got ord=%0d want ord=%0d", i, got_order[i], i);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bad_shape = 1'b0;
    clear_inputs();
    test_reset();
    test_in_order();
    test_burst8();
    test_full_wrap();
    test_halt();
    test_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
